// File: rtl/clk_switch_pkg.sv
// Shared definitions for the N-source clock-switch sequencer.
//   state_e : sequencer states, exported on the top's dbg_state port.
//   onehot  : source index -> gate-enable vector (16 bits wide, which covers every
//             legal source count); callers truncate it to their own N_SRC.
package clk_switch_pkg;

  typedef enum logic [2:0] {
    S_RUN         = 3'd0,
    S_PRE_OFF     = 3'd1,
    S_DEAD        = 3'd2,
    S_WAIT_LOCK   = 3'd3,
    S_GATE_ON     = 3'd4,
    S_RST_RELEASE = 3'd5
  } state_e;

  localparam int unsigned MAX_SRC = 16;

  function automatic logic [MAX_SRC-1:0] onehot(input logic [3:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/lock_qual.sv
// Lock qualifier for one clock source.
// The count rises while locked_i is high, saturates at LOCK_STABLE_CYC and is
// cleared by any cycle with locked_i low. stable_o is high only at saturation.
//   clk, rst  : reference clock, asynchronous active-high reset
//   locked_i  : source lock indication, already synchronised to clk
//   stable_o  : source has been locked for LOCK_STABLE_CYC consecutive cycles
module lock_qual #(
  parameter int unsigned LOCK_STABLE_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic locked_i,
  output logic stable_o
);

  localparam int unsigned CW = $clog2(LOCK_STABLE_CYC + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(LOCK_STABLE_CYC);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!locked_i) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign stable_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/clk_switch_seq.sv
// N-source clock-switch sequencer. Drives the enables of a glitch-free gated
// clock tree from a free-running reference clock, with break-before-make dead
// time, per-source lock qualification, automatic fallback and reset sequencing
// of the switched domain.
//   clk, rst       : reference clock, asynchronous active-high reset
//   sel_req/valid  : requested source index and its valid
//   sel_ready      : request can be accepted (combinational from registered state)
//   src_locked     : per-source lock, already synchronised to clk
//   gate_en        : registered gate enables, one-hot or zero
//   active_src     : index of the currently (or last) gated source
//   switching      : high whenever the sequencer is not in RUN
//   rst_out        : active-high reset for the switched domain
//   fallback_evt   : one-cycle pulse on every automatic retarget
//   err_bad_sel    : one-cycle pulse when an out-of-range index is accepted
//   dbg_state      : current sequencer state
//
// Handshake: a request transfers on a clk edge where sel_valid && sel_ready;
// sel_req is only looked at on that edge, sel_ready never depends on sel_valid,
// and the requester may hold or drop sel_valid freely while sel_ready is low.
module clk_switch_seq
  import clk_switch_pkg::*;
#(
  parameter int unsigned N_SRC           = 4,
  parameter int unsigned SEL_W           = $clog2(N_SRC),
  parameter int unsigned LOCK_STABLE_CYC = 16,
  parameter int unsigned DEAD_CYC        = 4,
  parameter int unsigned RST_HOLD_CYC    = 8,
  parameter int unsigned WAIT_TO_CYC     = 256,
  parameter int unsigned DEFAULT_SRC     = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SEL_W-1:0] sel_req,
  input  logic             sel_valid,
  output logic             sel_ready,
  input  logic [N_SRC-1:0] src_locked,
  output logic [N_SRC-1:0] gate_en,
  output logic [SEL_W-1:0] active_src,
  output logic             switching,
  output logic             rst_out,
  output logic             fallback_evt,
  output logic             err_bad_sel,
  output state_e           dbg_state
);

  // One timer serves DEAD, WAIT_LOCK and RST_RELEASE; sized for the longest.
  localparam int unsigned T_MAX =
    (WAIT_TO_CYC > DEAD_CYC)
      ? ((WAIT_TO_CYC > RST_HOLD_CYC) ? WAIT_TO_CYC : RST_HOLD_CYC)
      : ((DEAD_CYC > RST_HOLD_CYC) ? DEAD_CYC : RST_HOLD_CYC);
  localparam int unsigned TW = $clog2(T_MAX + 1);

  localparam logic [TW-1:0] DEAD_LAST = TW'(DEAD_CYC - 1);
  localparam logic [TW-1:0] WAIT_LAST = TW'(WAIT_TO_CYC - 1);
  // GATE_ON already holds rst_out for one cycle with the new gate running, so
  // RST_RELEASE supplies the rest and the domain sees exactly RST_HOLD_CYC
  // clocks in reset after its gate opens.
  localparam logic [TW-1:0] HOLD_LAST =
    TW'((RST_HOLD_CYC >= 2) ? (RST_HOLD_CYC - 2) : 0);

  localparam logic [SEL_W-1:0] DEF_SRC = SEL_W'(DEFAULT_SRC);
  localparam logic [SEL_W:0]   N_SRC_X = (SEL_W + 1)'(N_SRC);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] target_q, target_d;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic [N_SRC-1:0] gate_q, gate_d;
  logic [SEL_W-1:0] active_q, active_d;
  logic             rst_out_q, rst_out_d;
  logic             switching_q, switching_d;
  logic             fallback_q, fallback_d;
  logic             err_q, err_d;

  logic [N_SRC-1:0] stable;
  logic [SEL_W-1:0] fb_src;

  for (genvar i = 0; i < N_SRC; i++) begin : g_lq
    lock_qual #(
      .LOCK_STABLE_CYC(LOCK_STABLE_CYC)
    ) u_lock_qual (
      .clk      (clk),
      .rst      (rst),
      .locked_i (src_locked[i]),
      .stable_o (stable[i])
    );
  end

  // Retarget choice: lowest-index stable source, else the default source.
  always_comb begin
    fb_src = DEF_SRC;
    for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
      if (stable[i]) fb_src = SEL_W'(i);
    end
  end

  assign sel_ready = (state_q == S_RUN) && stable[active_q];

  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    tmr_d      = tmr_q;
    gate_d     = gate_q;
    active_d   = active_q;
    fallback_d = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      S_RUN: begin
        // Lock loss wins; sel_ready is already low in that case.
        if (!stable[active_q]) begin
          state_d    = S_PRE_OFF;
          target_d   = fb_src;
          fallback_d = 1'b1;
        end else if (sel_valid && sel_ready) begin
          if ({1'b0, sel_req} >= N_SRC_X) begin
            err_d = 1'b1;
          end else if (sel_req != active_q) begin
            target_d = sel_req;
            state_d  = S_PRE_OFF;
          end
        end
      end

      // The domain is put in reset one cycle before its clock stops.
      S_PRE_OFF: begin
        state_d = S_DEAD;
        tmr_d   = '0;
        gate_d  = '0;
      end

      S_DEAD: begin
        if (tmr_q == DEAD_LAST) begin
          state_d = S_WAIT_LOCK;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end

      S_WAIT_LOCK: begin
        if (stable[target_q]) begin
          state_d  = S_GATE_ON;
          gate_d   = N_SRC'(onehot(4'(target_q)));
          active_d = target_q;
        end else if (tmr_q == WAIT_LAST) begin
          // On the default source there is nothing left to fall back to.
          tmr_d = '0;
          if (target_q != DEF_SRC) begin
            target_d   = DEF_SRC;
            fallback_d = 1'b1;
          end
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end

      S_GATE_ON: begin
        if (!stable[target_q]) begin
          state_d    = S_PRE_OFF;
          target_d   = fb_src;
          fallback_d = 1'b1;
        end else begin
          state_d = S_RST_RELEASE;
          tmr_d   = '0;
        end
      end

      S_RST_RELEASE: begin
        if (!stable[target_q]) begin
          state_d    = S_PRE_OFF;
          target_d   = fb_src;
          fallback_d = 1'b1;
        end else if (tmr_q == HOLD_LAST) begin
          state_d = S_RUN;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end

      default: begin
        state_d = S_WAIT_LOCK;
        tmr_d   = '0;
        gate_d  = '0;
      end
    endcase

    // Domain reset and the busy flag are exactly "not in RUN".
    rst_out_d   = (state_d != S_RUN);
    switching_d = (state_d != S_RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_WAIT_LOCK;
      target_q    <= DEF_SRC;
      tmr_q       <= '0;
      gate_q      <= '0;
      active_q    <= DEF_SRC;
      rst_out_q   <= 1'b1;
      switching_q <= 1'b1;
      fallback_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      tmr_q       <= tmr_d;
      gate_q      <= gate_d;
      active_q    <= active_d;
      rst_out_q   <= rst_out_d;
      switching_q <= switching_d;
      fallback_q  <= fallback_d;
      err_q       <= err_d;
    end
  end

  assign gate_en      = gate_q;
  assign active_src   = active_q;
  assign switching    = switching_q;
  assign rst_out      = rst_out_q;
  assign fallback_evt = fallback_q;
  assign err_bad_sel  = err_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_clk_switch_seq.sv
// Directed self-checking bench for clk_switch_seq (N_SRC=4, plus an N_SRC=3
// instance for the out-of-range select case).
module tb_clk_switch_seq;
  import clk_switch_pkg::*;

  localparam int N    = 4;
  localparam int SW   = 2;
  localparam int LOCK = 16;
  localparam int DEAD = 4;
  localparam int HOLD = 8;
  localparam int TO   = 256;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [SW-1:0] sel_req;
  logic          sel_valid;
  logic          sel_ready;
  logic [N-1:0]  src_locked;
  logic [N-1:0]  gate_en;
  logic [SW-1:0] active_src;
  logic          switching, rst_out, fallback_evt, err_bad_sel;
  state_e        dbg_state;

  logic          rst3;
  logic [1:0]    sel_req3;
  logic          sel_valid3, sel_ready3;
  logic [2:0]    src_locked3, gate_en3;
  logic [1:0]    active_src3;
  logic          switching3, rst_out3, fallback_evt3, err_bad_sel3;
  state_e        dbg_state3;

  clk_switch_seq #(
    .N_SRC(N), .LOCK_STABLE_CYC(LOCK), .DEAD_CYC(DEAD),
    .RST_HOLD_CYC(HOLD), .WAIT_TO_CYC(TO), .DEFAULT_SRC(0)
  ) dut (
    .clk(clk), .rst(rst), .sel_req(sel_req), .sel_valid(sel_valid),
    .sel_ready(sel_ready), .src_locked(src_locked), .gate_en(gate_en),
    .active_src(active_src), .switching(switching), .rst_out(rst_out),
    .fallback_evt(fallback_evt), .err_bad_sel(err_bad_sel), .dbg_state(dbg_state)
  );

  clk_switch_seq #(
    .N_SRC(3), .LOCK_STABLE_CYC(LOCK), .DEAD_CYC(DEAD),
    .RST_HOLD_CYC(HOLD), .WAIT_TO_CYC(TO), .DEFAULT_SRC(0)
  ) dut3 (
    .clk(clk), .rst(rst3), .sel_req(sel_req3), .sel_valid(sel_valid3),
    .sel_ready(sel_ready3), .src_locked(src_locked3), .gate_en(gate_en3),
    .active_src(active_src3), .switching(switching3), .rst_out(rst_out3),
    .fallback_evt(fallback_evt3), .err_bad_sel(err_bad_sel3), .dbg_state(dbg_state3)
  );

  // ---------------- scoreboard counters ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int n_fb  = 0;
  int n_err = 0;
  logic [N-1:0] prev_gate    = '0;
  logic         prev_rst_out = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one clock and sample 1ns after the edge; also watches the
  // gate invariants and counts event pulses on the main instance.
  task automatic tick();
    @(posedge clk);
    #1;
    if (fallback_evt) n_fb++;
    if (err_bad_sel)  n_err++;
    check("gate_at_most_onehot", 32'($countones(gate_en) <= 1), 1);
    if (gate_en !== prev_gate)
      check("gate_change_under_rst", 32'(prev_rst_out && rst_out), 1);
    prev_gate    = gate_en;
    prev_rst_out = rst_out;
  endtask

  // ---------------- driver tasks ----------------
  task automatic issue_req(input logic [SW-1:0] req);
    sel_req   = req;
    sel_valid = 1'b1;
    tick();
    sel_valid = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int k = 0;
    while (!sel_ready && k < 400) begin tick(); k++; end
    check({tag, "_ready"}, 32'(sel_ready), 1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rv_gate"},      32'(gate_en), 0);
    check({tag, "_rv_active"},    32'(active_src), 0);
    check({tag, "_rv_switching"}, 32'(switching), 1);
    check({tag, "_rv_rst_out"},   32'(rst_out), 1);
    check({tag, "_rv_fallback"},  32'(fallback_evt), 0);
    check({tag, "_rv_err"},       32'(err_bad_sel), 0);
    check({tag, "_rv_ready"},     32'(sel_ready), 0);
  endtask

  // Called with rst high and src_locked = 4'b0001, just after a posedge.
  task automatic bringup(input string tag);
    int k;
    check_reset_vals(tag);
    rst = 1'b0;
    k = 0;
    while (gate_en == '0 && k < 200) begin tick(); k++; end
    // LOCK edges to qualify source 0, one more to open its gate.
    check({tag, "_gate_latency"}, 32'(k), LOCK + 1);
    check({tag, "_gate"}, 32'(gate_en), 32'b0001);
    k = 0;
    while (rst_out && k < 50) begin tick(); k++; end
    check({tag, "_rst_hold"}, 32'(k), HOLD);
    check({tag, "_switching"}, 32'(switching), 0);
    check({tag, "_ready_after"}, 32'(sel_ready), 1);
    check({tag, "_active"}, 32'(active_src), 0);
  endtask

  // ---------------- request table ----------------
  typedef struct {
    logic [SW-1:0] req;
    logic [SW-1:0] exp_active;
    logic [N-1:0]  exp_gate;
    logic          exp_switch;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int k;
    int fb0;
    logic saw_sw;
    logic [N-1:0] eg;

    vecs[0] = '{req: 2'd2, exp_active: 2'd2, exp_gate: 4'b0100, exp_switch: 1'b1};
    vecs[1] = '{req: 2'd2, exp_active: 2'd2, exp_gate: 4'b0100, exp_switch: 1'b0};
    vecs[2] = '{req: 2'd1, exp_active: 2'd1, exp_gate: 4'b0010, exp_switch: 1'b1};
    vecs[3] = '{req: 2'd3, exp_active: 2'd3, exp_gate: 4'b1000, exp_switch: 1'b1};
    vecs[4] = '{req: 2'd0, exp_active: 2'd0, exp_gate: 4'b0001, exp_switch: 1'b1};

    rst = 1'b1; sel_req = '0; sel_valid = 1'b0; src_locked = 4'b0001;
    rst3 = 1'b1; sel_req3 = '0; sel_valid3 = 1'b0; src_locked3 = 3'b111;
    tick(); tick();

    // 1: bring-up on the default source
    bringup("s1");

    // 2: switch 0 -> 2 with all sources locked, cycle-by-cycle
    src_locked = 4'b1111;
    repeat (LOCK + 2) tick();
    wait_ready("s2");
    issue_req(2'd2);
    for (int c = 0; c < 15; c++) begin
      if (c > 0) tick();
      eg = (c == 0) ? 4'b0001 : ((c < 6) ? 4'b0000 : 4'b0100);
      check($sformatf("s2_gate_c%0d", c), 32'(gate_en), 32'(eg));
      check($sformatf("s2_rst_out_c%0d", c), 32'(rst_out), 32'(c < 14));
    end
    check("s2_active", 32'(active_src), 2);
    check("s2_ready", 32'(sel_ready), 1);

    // 3: lock loss on active source 2, only 0 and 3 still stable
    fb0 = n_fb;
    src_locked = 4'b1001;
    k = 0;
    while (gate_en != 4'b0001 && k < 60) begin tick(); k++; end
    check("s3_gate", 32'(gate_en), 32'b0001);
    check("s3_gate_latency", 32'(k), 2 + DEAD + 2);
    check("s3_active", 32'(active_src), 0);
    check("s3_fb_pulses", 32'(n_fb - fb0), 1);
    k = 0;
    while (rst_out && k < 20) begin tick(); k++; end
    check("s3_rst_out", 32'(rst_out), 0);

    // table: request sequence from a stable RUN on source 0
    src_locked = 4'b1111;
    repeat (LOCK + 2) tick();
    for (int v = 0; v < 5; v++) begin
      wait_ready($sformatf("tbl%0d", v));
      fb0 = n_err;
      issue_req(vecs[v].req);
      saw_sw = switching;
      repeat (30) begin tick(); saw_sw |= switching; end
      check($sformatf("tbl%0d_active", v), 32'(active_src), 32'(vecs[v].exp_active));
      check($sformatf("tbl%0d_gate", v), 32'(gate_en), 32'(vecs[v].exp_gate));
      check($sformatf("tbl%0d_switch", v), 32'(saw_sw), 32'(vecs[v].exp_switch));
      check($sformatf("tbl%0d_no_err", v), 32'(n_err - fb0), 0);
    end

    // 4: request source 3 which never locks -> timeout fallback to 0
    src_locked = 4'b0111;
    tick();
    wait_ready("s4");
    fb0 = n_fb;
    issue_req(2'd3);
    k = 0;
    while (!fallback_evt && k < 400) begin tick(); k++; end
    check("s4_fb_latency", 32'(k), 1 + DEAD + TO);
    check("s4_gate_waiting", 32'(gate_en), 0);
    tick();
    check("s4_gate", 32'(gate_en), 32'b0001);
    check("s4_active", 32'(active_src), 0);
    check("s4_fb_pulses", 32'(n_fb - fb0), 1);
    k = 0;
    while (rst_out && k < 20) begin tick(); k++; end
    check("s4_rst_out", 32'(rst_out), 0);

    // 6: asynchronous reset in the middle of DEAD
    src_locked = 4'b1111;
    repeat (LOCK + 2) tick();
    wait_ready("s6");
    issue_req(2'd1);
    tick(); tick();
    check("s6_in_dead", 32'(dbg_state), 32'(S_DEAD));
    check("s6_dead_gate", 32'(gate_en), 0);
    #2 rst = 1'b1;
    #1;
    check_reset_vals("s6_async");
    check("s6_state", 32'(dbg_state), 32'(S_WAIT_LOCK));
    src_locked = 4'b0001;
    tick(); tick();
    bringup("s6");

    // 5: out-of-range select on a 3-source instance
    rst3 = 1'b0;
    k = 0;
    while (!sel_ready3 && k < 100) begin tick(); k++; end
    check("s5_ready", 32'(sel_ready3), 1);
    check("s5_gate_before", 32'(gate_en3), 32'b001);
    sel_req3 = 2'd3;
    sel_valid3 = 1'b1;
    tick();
    sel_valid3 = 1'b0;
    check("s5_err_pulse", 32'(err_bad_sel3), 1);
    check("s5_gate", 32'(gate_en3), 32'b001);
    check("s5_switching", 32'(switching3), 0);
    tick();
    check("s5_err_single", 32'(err_bad_sel3), 0);
    check("s5_gate_after", 32'(gate_en3), 32'b001);
    check("s5_active", 32'(active_src3), 0);
    check("s5_ready_after", 32'(sel_ready3), 1);

    check("main_no_bad_sel", 32'(n_err), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/clk_switch_seq.md
Name: clk_switch_seq

Overview:
- N-source clock-switch sequencer running on one free-running reference clock.
- Owns the gate enables for an N-way glitch-free clock tree, not the clocks themselves. Generalises the two-input mux control to N sources.
- Break-before-make dead time, per-source lock qualification, request/ready select handshake, automatic fallback on lock loss or timeout, and reset sequencing for the switched domain.
- Sits between the control/UART register block and the clock gating cells.

Parameters:
- N_SRC, 4, number of clock sources (2..16)
- SEL_W, $clog2(N_SRC), width of source index
- LOCK_STABLE_CYC, 16, consecutive locked cycles before a source is stable
- DEAD_CYC, 4, cycles with all gates off between sources
- RST_HOLD_CYC, 8, cycles rst_out stays high after new gate enabled
- WAIT_TO_CYC, 256, max cycles waiting for target stability
- DEFAULT_SRC, 0, source used after reset and as last-resort fallback

Ports:
- clk  in  1  reference clock, free-running
- rst  in  1  asynchronous active-high reset
- sel_req  in  SEL_W  requested source index
- sel_valid  in  1  request valid
- sel_ready  out  1  request can be accepted
- src_locked  in  N_SRC  per-source lock, already synchronised to clk
- gate_en  out  N_SRC  gate enables, one-hot or zero, registered
- active_src  out  SEL_W  index of currently or last gated source
- switching  out  1  high whenever state is not RUN
- rst_out  out  1  active-high reset for the switched domain
- fallback_evt  out  1  single-cycle pulse on automatic retarget
- err_bad_sel  out  1  single-cycle pulse when sel_req >= N_SRC is presented with sel_valid&sel_ready

Behaviour:
- Clock and reset: one clock domain; reset is asynchronous and active-high (rst); all outputs registered except sel_ready.
- Reset values: gate_en=0, active_src=DEFAULT_SRC, switching=1, rst_out=1, fallback_evt=0, err_bad_sel=0. After reset the state is WAIT_LOCK with target=DEFAULT_SRC.
- Lock qualification:
  - Per-source counter increments while src_locked[i]=1 and saturates at LOCK_STABLE_CYC.
  - Any cycle with src_locked[i]=0 clears the counter to 0.
  - stable[i] = (cnt[i]==LOCK_STABLE_CYC).
- sel_ready = (state==RUN) && stable[active_src]. Combinational from registered state.
- Handshake, on sel_valid&sel_ready:
  - sel_req >= N_SRC: err_bad_sel pulses next cycle; request dropped; stay in RUN.
  - sel_req == active_src: accepted as a no-op.
  - Otherwise: target <= sel_req and the FSM enters PRE_OFF.
- States:
  - RUN: gate_en[active_src]=1, rst_out=0.
    - If stable[active_src] drops, go to PRE_OFF. Target = lowest-index stable source, else DEFAULT_SRC. fallback_evt pulses.
    - Lock loss has priority over a simultaneous request; the request is not accepted because sel_ready is low.
  - PRE_OFF (1 cycle): rst_out=1, gates unchanged. The domain sees reset before its clock stops.
  - DEAD (DEAD_CYC cycles): gate_en=0.
  - WAIT_LOCK:
    - Wait for stable[target]; timeout counter counts to WAIT_TO_CYC.
    - On timeout with target!=DEFAULT_SRC: target <= DEFAULT_SRC, fallback_evt pulses, timeout counter restarts.
    - On timeout with target==DEFAULT_SRC: keep waiting, no pulse.
  - GATE_ON (1 cycle): gate_en <= onehot(target), active_src <= target.
  - RST_RELEASE (RST_HOLD_CYC cycles): rst_out=1, then go to RUN. rst_out=0 and switching=0 on the same edge.
- Latency, accept at edge T:
  - rst_out=1 at T+1.
  - gate_en=0 at T+2 and for DEAD_CYC cycles.
  - New gate no earlier than T+2+DEAD_CYC+1.
- Target loses stability in GATE_ON or RST_RELEASE: return to PRE_OFF with retarget as in RUN, and fallback_evt pulses.
- Invariants:
  - gate_en is never more than one-hot.
  - Gates change only while rst_out=1.
  - Zero cycles with two gates enabled on any transition.
- Async rst mid-switch: immediate return to the reset values; the sequence restarts from WAIT_LOCK.
- Counters are sized with $clog2(max+1); there is no wrap-around at saturation.

Decomposition:
- Package clk_switch_pkg: state enum (RUN, PRE_OFF, DEAD, WAIT_LOCK, GATE_ON, RST_RELEASE) and function onehot(idx).
- Sub-module lock_qual: one per-source stability counter, instantiated N_SRC times via generate.

Test Plan (N_SRC=4, LOCK=16, DEAD=4, HOLD=8, TO=256, DEFAULT=0):
- Reset release with src_locked=4'b0001 -> gate_en=0 for >=16 cycles, then 4'b0001, then rst_out=0 exactly 8 cycles later, then sel_ready=1.
- All sources locked, request sel_req=2 -> rst_out=1 at T+1, gate_en=0 for cycles T+2..T+5, gate_en=4'b0100, active_src=2, rst_out low 8 cycles later; never two gate bits high.
- Active src 2 with src_locked[2] dropped, only bits 0 and 3 stable -> fallback_evt one pulse, new gate_en=4'b0001.
- Request sel_req=3 while src3 never locks -> after 256 WAIT_LOCK cycles fallback_evt pulses and gate_en=4'b0001.
- sel_req=5 is unrepresentable at SEL_W=2; rerun with N_SRC=3 and sel_req=3 -> err_bad_sel one pulse, gate_en unchanged.
- Assert rst during DEAD state -> outputs at reset values next sample, recovery identical to scenario 1.
